sync_fifo: RTL and testbench

//  Single-clock parametrised FIFO: storage array, pointers, occupancy counter and status flags.

---
 rtl/fifo_pkg.sv | 23 ++
 rtl/sync_fifo_mem.sv | 35 +++
 rtl/sync_fifo.sv | 116 +++++++++++
 tb/tb_sync_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the FIFO family: mode constants, log2 and parameter legality checks.
package fifo_pkg;

   localparam string FIFO_MODE_FWFT = "TRUE";

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      if (v > 1) begin
         for (int unsigned x = v - 1; x != 0; x = x >> 1) r++;
      end
      return r;
   endfunction

   function automatic bit afull_lvl_ok(input int unsigned lvl, input int unsigned depth);
      return (lvl >= 1) && (lvl <= depth);
   endfunction

   function automatic bit aempty_lvl_ok(input int unsigned lvl, input int unsigned depth);
      return lvl <= (depth - 1);
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATASIZE storage with one write port and a read port that is either
// combinational (fall-through) or registered with a read enable.
module sync_fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATASIZE = 8,
   parameter int unsigned DEPTH    = 16,
   parameter bit          FWFT     = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        we_i,
   input  logic [clog2(DEPTH)-1:0]     waddr_i,
   input  logic [DATASIZE-1:0]         wdata_i,
   input  logic                        re_i,
   input  logic [clog2(DEPTH)-1:0]     raddr_i,
   output logic [DATASIZE-1:0]         rdata_o
);

   logic [DATASIZE-1:0] mem_q [DEPTH];
   logic [DATASIZE-1:0] rdata_q;

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = FWFT ? mem_q[raddr_i] : rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy counter, registered status flags and
// sticky overflow/underflow tracking around the sync_fifo_mem storage.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATASIZE    = 8,
   parameter int unsigned ADDRSIZE    = 4,
   parameter string       FALLTHROUGH = FIFO_MODE_FWFT,
   parameter int unsigned AFULL_LVL   = (1 << ADDRSIZE) - 1,
   parameter int unsigned AEMPTY_LVL  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [DATASIZE-1:0]   wdata,
   output logic                  wfull,
   output logic                  awfull,
   input  logic                  rinc,
   output logic [DATASIZE-1:0]   rdata,
   output logic                  rempty,
   output logic                  arempty,
   output logic [ADDRSIZE:0]     count,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int unsigned DEPTH = 1 << ADDRSIZE;
   localparam int unsigned CW    = ADDRSIZE + 1;
   localparam bit          FWFT  = (FALLTHROUGH == FIFO_MODE_FWFT);

   if (DATASIZE < 1 || ADDRSIZE < 1) begin : g_bad_size
      $error("sync_fifo: DATASIZE and ADDRSIZE must be >= 1");
   end
   if (!afull_lvl_ok(AFULL_LVL, DEPTH)) begin : g_bad_afull
      $error("sync_fifo: AFULL_LVL must lie in 1..DEPTH");
   end
   if (!aempty_lvl_ok(AEMPTY_LVL, DEPTH)) begin : g_bad_aempty
      $error("sync_fifo: AEMPTY_LVL must lie in 0..DEPTH-1");
   end

   logic [ADDRSIZE-1:0] wptr_q, wptr_d;
   logic [ADDRSIZE-1:0] rptr_q, rptr_d;
   logic [CW-1:0]       count_q, count_d;
   logic                wfull_q, wfull_d;
   logic                awfull_q, awfull_d;
   logic                rempty_q, rempty_d;
   logic                arempty_q, arempty_d;
   logic                overflow_q, overflow_d;
   logic                underflow_q, underflow_d;
   logic                wen, ren;

   // Flags are derived from the next count so they move on the same edge as count.
   always_comb begin
      wen         = winc & ~wfull_q;
      ren         = rinc & ~rempty_q;
      wptr_d      = wptr_q + ADDRSIZE'(wen);
      rptr_d      = rptr_q + ADDRSIZE'(ren);
      count_d     = count_q + CW'(wen) - CW'(ren);
      wfull_d     = (count_d == CW'(DEPTH));
      awfull_d    = (count_d >= CW'(AFULL_LVL));
      rempty_d    = (count_d == '0);
      arempty_d   = (count_d <= CW'(AEMPTY_LVL));
      // A new error in the same cycle as clr_err keeps the flag set.
      overflow_d  = (winc & wfull_q)  | (overflow_q  & ~clr_err);
      underflow_d = (rinc & rempty_q) | (underflow_q & ~clr_err);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         wfull_q     <= 1'b0;
         awfull_q    <= 1'b0;
         rempty_q    <= 1'b1;
         arempty_q   <= 1'b1;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         wfull_q     <= wfull_d;
         awfull_q    <= awfull_d;
         rempty_q    <= rempty_d;
         arempty_q   <= arempty_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sync_fifo_mem #(
      .DATASIZE (DATASIZE),
      .DEPTH    (DEPTH),
      .FWFT     (FWFT)
   ) u_mem (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (wen),
      .waddr_i (wptr_q),
      .wdata_i (wdata),
      .re_i    (ren),
      .raddr_i (rptr_q),
      .rdata_o (rdata)
   );

   assign wfull     = wfull_q;
   assign awfull    = awfull_q;
   assign rempty    = rempty_q;
   assign arempty   = arempty_q;
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one fall-through instance and one registered-read instance.
module tb_sync_fifo;

   logic       clk;
   logic       rst_n;

   logic       a_winc, a_rinc, a_clr;
   logic [7:0] a_wdata, a_rdata;
   logic       a_wfull, a_awfull, a_rempty, a_arempty, a_ovf, a_unf;
   logic [4:0] a_count;

   logic       b_winc, b_rinc, b_clr;
   logic [7:0] b_wdata, b_rdata;
   logic       b_wfull, b_awfull, b_rempty, b_arempty, b_ovf, b_unf;
   logic [4:0] b_count;

   int checks = 0;
   int errors = 0;

   sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE")) u_ft (
      .clk(clk), .rst_n(rst_n),
      .winc(a_winc), .wdata(a_wdata), .wfull(a_wfull), .awfull(a_awfull),
      .rinc(a_rinc), .rdata(a_rdata), .rempty(a_rempty), .arempty(a_arempty),
      .count(a_count), .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr)
   );

   sync_fifo #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE")) u_rg (
      .clk(clk), .rst_n(rst_n),
      .winc(b_winc), .wdata(b_wdata), .wfull(b_wfull), .awfull(b_awfull),
      .rinc(b_rinc), .rdata(b_rdata), .rempty(b_rempty), .arempty(b_arempty),
      .count(b_count), .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_winc = 0; a_rinc = 0; a_clr = 0; a_wdata = '0;
      b_winc = 0; b_rinc = 0; b_clr = 0; b_wdata = '0;
      #12;

      // Reset state
      chk("rst_rempty",   32'(a_rempty),  1);
      chk("rst_arempty",  32'(a_arempty), 1);
      chk("rst_wfull",    32'(a_wfull),   0);
      chk("rst_awfull",   32'(a_awfull),  0);
      chk("rst_count",    32'(a_count),   0);
      chk("rst_ovf",      32'(a_ovf),     0);
      chk("rst_unf",      32'(a_unf),     0);
      chk("rst_b_rdata",  32'(b_rdata),   0);
      rst_n = 1'b1;
      step();
      chk("idle_rempty",  32'(a_rempty),  1);
      chk("idle_count",   32'(a_count),   0);

      // Fill 16 words
      for (int i = 0; i < 16; i++) begin
         a_winc = 1; a_wdata = 8'(i);
         step();
         chk("fill_count",  32'(a_count),  32'(i + 1));
         chk("fill_awfull", 32'(a_awfull), 32'(i + 1 >= 15));
         chk("fill_wfull",  32'(a_wfull),  32'(i + 1 == 16));
      end
      a_winc = 0;
      chk("full_head", 32'(a_rdata), 32'h00);

      // Full: write dropped, read proceeds
      a_winc = 1; a_rinc = 1; a_wdata = 8'hEE;
      step();
      a_winc = 0; a_rinc = 0;
      chk("ovf_count",  32'(a_count),  15);
      chk("ovf_flag",   32'(a_ovf),    1);
      chk("ovf_wfull",  32'(a_wfull),  0);
      chk("ovf_awfull", 32'(a_awfull), 1);
      chk("ovf_head",   32'(a_rdata),  32'h01);
      a_clr = 1;
      step();
      a_clr = 0;
      chk("ovf_clr", 32'(a_ovf), 0);

      // Drain
      for (int i = 1; i < 16; i++) begin
         chk("drain_data", 32'(a_rdata), 32'(i));
         a_rinc = 1;
         step();
      end
      a_rinc = 0;
      chk("drain_rempty",  32'(a_rempty),  1);
      chk("drain_count",   32'(a_count),   0);
      chk("drain_arempty", 32'(a_arempty), 1);
      chk("drain_unf",     32'(a_unf),     0);

      // Empty: read ignored, write proceeds
      a_winc = 1; a_rinc = 1; a_wdata = 8'hA5;
      step();
      a_winc = 0; a_rinc = 0;
      chk("unf_count",   32'(a_count),   1);
      chk("unf_flag",    32'(a_unf),     1);
      chk("unf_rempty",  32'(a_rempty),  0);
      chk("unf_arempty", 32'(a_arempty), 1);
      chk("unf_rdata",   32'(a_rdata),   32'hA5);
      a_rinc = 1;
      step();
      chk("unf_pop_count", 32'(a_count), 0);
      a_clr = 1;
      step();
      chk("unf_set_wins", 32'(a_unf), 1);
      a_rinc = 0;
      step();
      a_clr = 0;
      chk("unf_clr", 32'(a_unf), 0);

      // Registered read mode
      for (int i = 0; i < 3; i++) begin
         b_winc = 1; b_wdata = 8'(8'h31 + i);
         step();
      end
      b_winc = 0;
      chk("reg_count", 32'(b_count), 3);
      chk("reg_nopop", 32'(b_rdata), 0);
      b_rinc = 1;
      for (int j = 0; j < 3; j++) begin
         step();
         chk("reg_data", 32'(b_rdata), 32'(8'h31 + j));
      end
      b_rinc = 0;
      chk("reg_rempty", 32'(b_rempty), 1);
      step();
      chk("reg_hold", 32'(b_rdata), 32'h33);

      // Pointer wrap: 40 simultaneous push/pop with one word in flight
      b_winc = 1; b_wdata = 8'h80;
      step();
      for (int k = 0; k < 40; k++) begin
         b_winc = 1; b_rinc = 1; b_wdata = 8'(8'h40 + k);
         step();
         chk("wrap_data",  32'(b_rdata), (k == 0) ? 32'h80 : 32'(8'h40 + k - 1));
         chk("wrap_count", 32'(b_count), 1);
      end
      b_winc = 0; b_rinc = 0;

      // Reset mid-stream
      for (int i = 0; i < 7; i++) begin
         a_winc = 1; a_wdata = 8'(8'h10 + i);
         step();
      end
      a_winc = 0;
      chk("mid_count7", 32'(a_count), 7);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_count",  32'(a_count),  0);
      chk("mid_rst_rempty", 32'(a_rempty), 1);
      chk("mid_rst_wfull",  32'(a_wfull),  0);
      rst_n = 1'b1;
      a_winc = 1; a_wdata = 8'h5A;
      step();
      a_winc = 0;
      chk("post_rst_count", 32'(a_count), 1);
      chk("post_rst_data",  32'(a_rdata), 32'h5A);
      a_rinc = 1;
      step();
      a_rinc = 0;
      chk("post_rst_rempty", 32'(a_rempty), 1);
      chk("post_rst_empty_count", 32'(a_count), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
